pong_ball_engine: RTL

- Parametrised game-logic core for the pong design: ball position/direction, paddle collision, wall bounce, scoring and serve/game-over sequencing.
- Advances once per video frame on a one-cycle frame_tick strobe.
- Sits beside the sync generator and display blocks. Its registered ball and score outputs feed the ball/score renderers, replacing the fixed score registers of the current top level.

---
 rtl/pong_ball_engine_if.sv | 34 +++
 rtl/pong_ball_engine.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine_if.sv
// Frame-rate control inputs and registered ball/score outputs of the pong ball engine.
interface pong_ball_engine_if #(
  parameter int X_W     = 9,
  parameter int Y_W     = 8,
  parameter int SCORE_W = 4
);
  logic               frame_tick;
  logic               start;
  logic [Y_W-1:0]     paddle_left_y;
  logic [Y_W-1:0]     paddle_right_y;
  logic [X_W-1:0]     ball_x;
  logic [Y_W-1:0]     ball_y;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic               point_left;
  logic               point_right;
  logic               paddle_hit;
  logic               game_over;
  logic               serving;

  // Game controller / video side: drives ticks and paddles, consumes ball and scores
  modport master (
    output frame_tick, start, paddle_left_y, paddle_right_y,
    input  ball_x, ball_y, score_left, score_right,
    input  point_left, point_right, paddle_hit, game_over, serving
  );

  // Ball engine side
  modport slave (
    input  frame_tick, start, paddle_left_y, paddle_right_y,
    output ball_x, ball_y, score_left, score_right,
    output point_left, point_right, paddle_hit, game_over, serving
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Pong game-logic core: ball motion, wall bounce, paddle returns, scoring and
// serve / game-over sequencing. Advances once per frame_tick; all outputs registered.
module pong_ball_engine #(
  parameter int H_RES        = 256,
  parameter int V_RES        = 240,
  parameter int X_W          = 9,
  parameter int Y_W          = 8,
  parameter int BALL_SIZE    = 4,
  parameter int PADDLE_H     = 16,
  parameter int PADDLE_W     = 4,
  parameter int PADDLE_LX    = 16,
  parameter int PADDLE_RX    = 236,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 11
) (
  input  logic                clk,
  input  logic                reset,
  pong_ball_engine_if.slave   bus
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  // Narrow constants used for register updates
  localparam logic [X_W-1:0] CX      = X_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [Y_W-1:0] CY      = Y_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [X_W-1:0] SX_N    = X_W'(SPEED_X);
  localparam logic [Y_W-1:0] SY_N    = Y_W'(SPEED_Y);
  localparam logic [X_W-1:0] LE_N    = X_W'(PADDLE_LX + PADDLE_W);
  localparam logic [X_W-1:0] RSTOP_N = X_W'(PADDLE_RX - BALL_SIZE);
  localparam logic [Y_W-1:0] YMAX_N  = Y_W'(V_RES - BALL_SIZE);

  // One-bit-wider constants used for wrap-free comparisons
  localparam logic [X_W:0] W_HRES = (X_W+1)'(H_RES);
  localparam logic [X_W:0] W_BSX  = (X_W+1)'(BALL_SIZE);
  localparam logic [X_W:0] W_SX   = (X_W+1)'(SPEED_X);
  localparam logic [X_W:0] W_LE   = (X_W+1)'(PADDLE_LX + PADDLE_W);
  localparam logic [X_W:0] W_RX   = (X_W+1)'(PADDLE_RX);
  localparam logic [Y_W:0] W_YMAX = (Y_W+1)'(V_RES - BALL_SIZE);
  localparam logic [Y_W:0] W_BSY  = (Y_W+1)'(BALL_SIZE);
  localparam logic [Y_W:0] W_SY   = (Y_W+1)'(SPEED_Y);
  localparam logic [Y_W:0] W_PH   = (Y_W+1)'(PADDLE_H);

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    SERVE,
    PLAY,
    OVER
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic               dx_q, dx_d;   // 1 = moving right
  logic               dy_q, dy_d;   // 1 = moving down
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic               pt_l_q, pt_l_d;
  logic               pt_r_q, pt_r_d;
  logic               hit_q, hit_d;
  logic               serving_q, over_q;

  logic [X_W:0]       xe;
  logic [Y_W:0]       ye, ple, pre;
  logic               ov_l, ov_r;
  logic               hit_l, hit_r, miss_l, miss_r;
  logic [Y_W-1:0]     y_mv;
  logic               dy_mv;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;

  // Collision, miss and vertical-move decode from the current (pre-move) ball position
  always_comb begin
    xe  = {1'b0, x_q};
    ye  = {1'b0, y_q};
    ple = {1'b0, bus.paddle_left_y};
    pre = {1'b0, bus.paddle_right_y};

    ov_l = (ye + W_BSY > ple) && (ye < ple + W_PH);
    ov_r = (ye + W_BSY > pre) && (ye < pre + W_PH);

    // x - SPEED_X < LE rewritten as x < LE + SPEED_X so nothing can underflow
    hit_l  = !dx_q && (xe >= W_LE) && (xe < W_LE + W_SX) && ov_l;
    hit_r  =  dx_q && (xe + W_BSX <= W_RX) && (xe + W_BSX + W_SX > W_RX) && ov_r;
    miss_l = !dx_q && (xe < W_SX);
    miss_r =  dx_q && (xe + W_BSX + W_SX > W_HRES);

    y_mv  = y_q;
    dy_mv = dy_q;
    if (dy_q) begin
      if (ye + W_SY >= W_YMAX) begin
        y_mv  = YMAX_N;
        dy_mv = 1'b0;
      end else begin
        y_mv = y_q + SY_N;
      end
    end else begin
      if (ye < W_SY) begin
        y_mv  = '0;
        dy_mv = 1'b1;
      end else begin
        y_mv = y_q - SY_N;
      end
    end

    score_l_inc = score_l_q + SCORE_W'(1);
    score_r_inc = score_r_q + SCORE_W'(1);
  end

  // Next-state: serve countdown, per-frame play update, restart from game over
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    pt_l_d    = 1'b0;
    pt_r_d    = 1'b0;
    hit_d     = 1'b0;

    unique case (state_q)
      SERVE: begin
        if (bus.frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            cnt_d   = '0;
            state_d = PLAY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      PLAY: begin
        if (bus.frame_tick) begin
          if (miss_l || miss_r) begin
            // Scoring tick: vertical move is dropped, ball re-centred toward the conceder
            x_d   = CX;
            y_d   = CY;
            cnt_d = '0;
            if (miss_l) begin
              score_r_d = score_r_inc;
              pt_r_d    = 1'b1;
              dx_d      = 1'b0;
              state_d   = (score_r_inc == WIN) ? OVER : SERVE;
            end else begin
              score_l_d = score_l_inc;
              pt_l_d    = 1'b1;
              dx_d      = 1'b1;
              state_d   = (score_l_inc == WIN) ? OVER : SERVE;
            end
          end else begin
            y_d  = y_mv;
            dy_d = dy_mv;
            if (hit_l) begin
              x_d   = LE_N;
              dx_d  = 1'b1;
              hit_d = 1'b1;
            end else if (hit_r) begin
              x_d   = RSTOP_N;
              dx_d  = 1'b0;
              hit_d = 1'b1;
            end else if (dx_q) begin
              x_d = x_q + SX_N;
            end else begin
              x_d = x_q - SX_N;
            end
          end
        end
      end

      OVER: begin
        if (bus.start) begin
          score_l_d = '0;
          score_r_d = '0;
          dx_d      = 1'b1;
          cnt_d     = '0;
          state_d   = SERVE;
        end
      end

      default: begin
        state_d = SERVE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= SERVE;
      cnt_q     <= '0;
      x_q       <= CX;
      y_q       <= CY;
      dx_q      <= 1'b1;
      dy_q      <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      pt_l_q    <= 1'b0;
      pt_r_q    <= 1'b0;
      hit_q     <= 1'b0;
      serving_q <= 1'b1;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      pt_l_q    <= pt_l_d;
      pt_r_q    <= pt_r_d;
      hit_q     <= hit_d;
      serving_q <= (state_d == SERVE);
      over_q    <= (state_d == OVER);
    end
  end

  assign bus.ball_x      = x_q;
  assign bus.ball_y      = y_q;
  assign bus.score_left  = score_l_q;
  assign bus.score_right = score_r_q;
  assign bus.point_left  = pt_l_q;
  assign bus.point_right = pt_r_q;
  assign bus.paddle_hit  = hit_q;
  assign bus.game_over   = over_q;
  assign bus.serving     = serving_q;

endmodule
